// File: rtl/kb_input_pkg.sv
// -----------------------------------------------------------------------------
// kb_input_pkg
// Purpose : Shared definitions for the keyboard front end / piece-spawn block.
//           Holds the key channel indices, the spawn FSM state type, the
//           auto-repeat phase type, the piece index type and the game state
//           encoding that means "playing".
// Contents:
//   K_LEFT..K_ENTER   channel index of each decoded key
//   PLAY_STATE        Game_State encoding for "playing"
//   piece_t           3-bit piece index (up to 8 piece kinds)
//   spawn_state_t     IDLE / SEARCH / READY
//   repeat_phase_t    DAS (initial delay) / ARR (steady repeat)
//   piece_wrap_inc    next piece index, wrapping at the number of kinds
// -----------------------------------------------------------------------------
package kb_input_pkg;

  localparam int K_LEFT  = 0;
  localparam int K_RIGHT = 1;
  localparam int K_UP    = 2;
  localparam int K_DOWN  = 3;
  localparam int K_SPACE = 4;
  localparam int K_ENTER = 5;

  localparam logic [2:0] PLAY_STATE = 3'b001;

  typedef logic [2:0] piece_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    READY  = 2'd2
  } spawn_state_t;

  typedef enum logic {
    PH_DAS = 1'b0,
    PH_ARR = 1'b1
  } repeat_phase_t;

  // Step a piece index forward by one, wrapping back to 0 after the last kind.
  function automatic piece_t piece_wrap_inc(input piece_t p, input int unsigned num_pieces);
    if ((32'(p) + 32'd1) >= num_pieces) begin
      piece_wrap_inc = piece_t'(0);
    end else begin
      piece_wrap_inc = p + piece_t'(1);
    end
  endfunction

endpackage

// File: rtl/key_repeat_ch.sv
// -----------------------------------------------------------------------------
// key_repeat_ch
// Purpose : One decoded key channel. Turns the per-cycle "this key is down"
//           match into a registered held level plus a press output that is
//           either a level, a single press pulse, or a press pulse followed
//           by DAS/ARR auto-repeat pulses counted in frame_rise events.
// Ports   :
//   Clk         in   system clock
//   Reset       in   synchronous, active-high
//   match       in   keycode currently equals this channel's code
//   frame_rise  in   one-cycle strobe on each rising edge of the frame clock
//   press       out  registered press level / pulse
//   held        out  registered match
// -----------------------------------------------------------------------------
module key_repeat_ch #(
  parameter bit IS_REPEAT  = 1'b0,
  parameter bit IS_LEVEL   = 1'b0,
  parameter int DAS_FRAMES = 10,
  parameter int ARR_FRAMES = 2,
  parameter int CNT_W      = 6
) (
  input  logic Clk,
  input  logic Reset,
  input  logic match,
  input  logic frame_rise,
  output logic press,
  output logic held
);

  import kb_input_pkg::*;

  localparam logic [CNT_W-1:0] DAS_C = CNT_W'(DAS_FRAMES);
  localparam logic [CNT_W-1:0] ARR_C = CNT_W'(ARR_FRAMES);

  logic             r_match_q;
  logic             r_press;
  logic             r_held;
  repeat_phase_t    r_phase;
  logic [CNT_W-1:0] r_cnt;

  logic             w_press_next;
  repeat_phase_t    w_phase_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_cnt_inc;

  assign w_cnt_inc = r_cnt + CNT_W'(1);

  // Registered channel state: previous match for edge detection, the
  // repeat phase/counter and the two outputs.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_match_q <= 1'b0;
      r_press   <= 1'b0;
      r_held    <= 1'b0;
      r_phase   <= PH_DAS;
      r_cnt     <= '0;
    end else begin
      r_match_q <= match;
      r_press   <= w_press_next;
      r_held    <= match;
      r_phase   <= w_phase_next;
      r_cnt     <= w_cnt_next;
    end
  end

  // Press decision. A fresh press always restarts the repeat timer, even if
  // a frame rise lands in the same cycle, so the first repeat is always a
  // full DAS_FRAMES rises after the press pulse.
  always_comb begin
    w_press_next = 1'b0;
    w_phase_next = r_phase;
    w_cnt_next   = r_cnt;
    if (IS_LEVEL) begin
      w_press_next = match;
    end else if (!match) begin
      w_phase_next = PH_DAS;
      w_cnt_next   = '0;
    end else if (!r_match_q) begin
      w_press_next = 1'b1;
      w_phase_next = PH_DAS;
      w_cnt_next   = '0;
    end else if (IS_REPEAT && frame_rise) begin
      if (r_phase == PH_DAS) begin
        if (w_cnt_inc == DAS_C) begin
          w_press_next = 1'b1;
          w_phase_next = PH_ARR;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end else begin
        if (w_cnt_inc == ARR_C) begin
          w_press_next = 1'b1;
          w_cnt_next   = '0;
        end else begin
          w_cnt_next = w_cnt_inc;
        end
      end
    end
  end

  assign press = r_press;
  assign held  = r_held;

endmodule

// File: rtl/kb_input_repeat.sv
// -----------------------------------------------------------------------------
// kb_input_repeat
// Purpose : Keyboard front end and piece-spawn source for the Tetris datapath.
//           Decodes the USB keycode into key channels (press / level / DAS-ARR
//           auto-repeat) and runs a 7-bag randomiser that issues one-hot
//           spawn pulses on frame clock rises while the game is playing.
// Ports   :
//   Clk            in   system clock, all logic on posedge
//   Reset          in   synchronous, active-high
//   frame_clk      in   frame-rate clock, sampled as data
//   keycode        in   current USB keycode, 0 = none
//   randnum        in   free-running random value
//   Game_State     in   game FSM state
//   En_New_Static  in   board ready to accept a new piece
//   key_press      out  per-channel press pulse / level
//   key_held       out  per-channel registered keycode match
//   Active         out  one-hot spawn pulse, one cycle
//   next_piece     out  piece index the next spawn will use
// -----------------------------------------------------------------------------
module kb_input_repeat #(
  parameter int                    NUM_KEYS    = 6,
  parameter logic [8*NUM_KEYS-1:0] KEY_CODES   = {8'd40, 8'd44, 8'd81, 8'd82, 8'd79, 8'd80},
  parameter logic [NUM_KEYS-1:0]   REPEAT_MASK = 6'b001011,
  parameter logic [NUM_KEYS-1:0]   LEVEL_MASK  = 6'b010000,
  parameter int                    DAS_FRAMES  = 10,
  parameter int                    ARR_FRAMES  = 2,
  parameter int                    CNT_W       = 6,
  parameter int                    NUM_PIECES  = 7,
  parameter logic [2:0]            PLAY_STATE  = 3'b001
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  frame_clk,
  input  logic [7:0]            keycode,
  input  logic [2:0]            randnum,
  input  logic [2:0]            Game_State,
  input  logic                  En_New_Static,
  output logic [NUM_KEYS-1:0]   key_press,
  output logic [NUM_KEYS-1:0]   key_held,
  output logic [NUM_PIECES-1:0] Active,
  output logic [2:0]            next_piece
);

  import kb_input_pkg::*;

  logic                  r_frame_q;
  logic [2:0]            r_game_q;
  spawn_state_t          r_state;
  piece_t                r_cand;
  piece_t                r_next_piece;
  logic [NUM_PIECES-1:0] r_active;
  logic [NUM_PIECES-1:0] r_bag;

  logic                  w_frame_rise;
  logic                  w_frame_fall;
  logic                  w_playing;
  logic                  w_enter_play;
  logic [NUM_KEYS-1:0]   w_match;
  logic [NUM_KEYS-1:0]   w_press;
  logic [NUM_KEYS-1:0]   w_held;
  piece_t                w_rand_cand;
  logic [NUM_PIECES-1:0] w_onehot;
  spawn_state_t          w_state_next;
  piece_t                w_cand_next;
  piece_t                w_next_piece_next;
  logic [NUM_PIECES-1:0] w_active_next;
  logic [NUM_PIECES-1:0] w_spawn_mask;
  logic [NUM_PIECES-1:0] w_bag_merged;
  logic [NUM_PIECES-1:0] w_bag_next;

  assign w_frame_rise = frame_clk & ~r_frame_q;
  assign w_frame_fall = ~frame_clk & r_frame_q;
  assign w_playing    = (Game_State == PLAY_STATE);
  assign w_enter_play = w_playing && (r_game_q != PLAY_STATE);
  assign w_rand_cand  = piece_t'(32'(randnum) % NUM_PIECES);

  // One channel per key; a level channel ignores its repeat bit.
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    assign w_match[g] = (keycode == KEY_CODES[g*8 +: 8]);

    key_repeat_ch #(
      .IS_REPEAT (REPEAT_MASK[g]),
      .IS_LEVEL  (LEVEL_MASK[g]),
      .DAS_FRAMES(DAS_FRAMES),
      .ARR_FRAMES(ARR_FRAMES),
      .CNT_W     (CNT_W)
    ) u_ch (
      .Clk       (Clk),
      .Reset     (Reset),
      .match     (w_match[g]),
      .frame_rise(w_frame_rise),
      .press     (w_press[g]),
      .held      (w_held[g])
    );
  end

  assign key_press = w_press;
  assign key_held  = w_held;

  // One-hot of the piece waiting to be spawned.
  always_comb begin
    w_onehot               = '0;
    w_onehot[r_next_piece] = 1'b1;
  end

  // Edge-detect registers plus the spawn FSM and bag state.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_frame_q    <= 1'b0;
      r_game_q     <= '0;
      r_state      <= IDLE;
      r_cand       <= '0;
      r_next_piece <= '0;
      r_active     <= '0;
      r_bag        <= '0;
    end else begin
      r_frame_q    <= frame_clk;
      r_game_q     <= Game_State;
      r_state      <= w_state_next;
      r_cand       <= w_cand_next;
      r_next_piece <= w_next_piece_next;
      r_active     <= w_active_next;
      r_bag        <= w_bag_next;
    end
  end

  // Spawn FSM. Every frame fall restarts the draw from a fresh random
  // candidate; SEARCH walks forward past pieces already taken from the bag,
  // which always terminates because a full bag is emptied on the spot.
  // A rise only spawns once the search has settled into READY.
  always_comb begin
    w_state_next      = r_state;
    w_cand_next       = r_cand;
    w_next_piece_next = r_next_piece;
    w_active_next     = '0;
    w_spawn_mask      = '0;
    if (w_frame_fall) begin
      w_cand_next  = w_rand_cand;
      w_state_next = SEARCH;
    end else begin
      case (r_state)
        IDLE: begin
        end
        SEARCH: begin
          if (r_bag[r_cand]) begin
            w_cand_next = piece_wrap_inc(r_cand, unsigned'(NUM_PIECES));
          end else begin
            w_next_piece_next = r_cand;
            w_state_next      = READY;
          end
        end
        READY: begin
          if (w_frame_rise && w_playing && En_New_Static) begin
            w_spawn_mask  = w_onehot;
            w_active_next = w_onehot;
            w_state_next  = IDLE;
          end
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end

    // Entering play empties the bag; a spawn in that same cycle counts as the
    // first draw of the new bag.
    w_bag_merged = (w_enter_play ? '0 : r_bag) | w_spawn_mask;
    w_bag_next   = (&w_bag_merged) ? '0 : w_bag_merged;
  end

  assign Active     = r_active;
  assign next_piece = r_next_piece;

endmodule

// File: tb/tb_kb_input_repeat.sv
// -----------------------------------------------------------------------------
// tb_kb_input_repeat
// Purpose : Self-checking bench for kb_input_repeat. A behavioural model
//           counts frame rises per held key and draws bag pieces in zero
//           time; its outputs are compared with the DUT after every clock.
//           Directed scenarios add literal expectations on pulse counts and
//           on the spawn order.
// -----------------------------------------------------------------------------
module tb_kb_input_repeat;

  import kb_input_pkg::*;

  localparam int NK  = 6;
  localparam int NP  = 7;
  localparam int DAS = 10;
  localparam int ARR = 2;
  localparam int H   = 10;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          frame_clk;
  logic [7:0]    keycode;
  logic [2:0]    randnum;
  logic [2:0]    Game_State;
  logic          En_New_Static;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_held;
  logic [NP-1:0] Active;
  logic [2:0]    next_piece;

  int checks = 0;
  int errors = 0;

  // Key table: channel -> USB keycode and behaviour class.
  int keyCode[NK] = '{80, 79, 82, 81, 44, 40};
  bit isRep[NK]   = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  bit isLvl[NK]   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  kb_input_repeat dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .keycode      (keycode),
    .randnum      (randnum),
    .Game_State   (Game_State),
    .En_New_Static(En_New_Static),
    .key_press    (key_press),
    .key_held     (key_held),
    .Active       (Active),
    .next_piece   (next_piece)
  );

  always #5 Clk = ~Clk;

  // Comparison helper: counts every check and reports a mismatch.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model, evaluated on the inputs seen at each rising clock.
  logic [NK-1:0] expPress;
  logic [NK-1:0] expHeld;
  logic [NP-1:0] expActive;
  logic [2:0]    expNext;
  bit            prevMatch[NK];
  int            rises[NK];
  bit            prevFrame;
  logic [2:0]    prevGame;
  bit            bagUsed[NP];
  bit            pending;
  bit            isReady;
  int            readyAt;
  int            pendPiece;
  int            cyc = 0;

  always @(posedge Clk) begin : model
    bit m, p, fr, ff, enter, full;
    int c, skips;
    cyc++;
    if (Reset) begin
      expPress  = '0;
      expHeld   = '0;
      expActive = '0;
      expNext   = '0;
      for (int i = 0; i < NK; i++) begin
        prevMatch[i] = 1'b0;
        rises[i]     = 0;
      end
      for (int k = 0; k < NP; k++) bagUsed[k] = 1'b0;
      prevFrame = 1'b0;
      prevGame  = '0;
      pending   = 1'b0;
      isReady   = 1'b0;
    end else begin
      fr = frame_clk && !prevFrame;
      ff = !frame_clk && prevFrame;
      for (int i = 0; i < NK; i++) begin
        m = (int'(keycode) == keyCode[i]);
        p = 1'b0;
        if (isLvl[i]) begin
          p = m;
        end else if (!m) begin
          rises[i] = 0;
        end else if (!prevMatch[i]) begin
          p = 1'b1;
          rises[i] = 0;
        end else if (isRep[i] && fr) begin
          rises[i]++;
          if (rises[i] == DAS) p = 1'b1;
          else if (rises[i] > DAS && ((rises[i] - DAS) % ARR) == 0) p = 1'b1;
        end
        expHeld[i]   = m;
        expPress[i]  = p;
        prevMatch[i] = m;
      end

      expActive = '0;
      enter = (Game_State == 3'd1) && (prevGame != 3'd1);
      if (enter) for (int k = 0; k < NP; k++) bagUsed[k] = 1'b0;
      if (ff) begin
        c = int'(randnum) % NP;
        skips = 0;
        while (bagUsed[c] && skips < NP) begin
          c = (c + 1) % NP;
          skips++;
        end
        pendPiece = c;
        readyAt   = cyc + 1 + skips;
        pending   = 1'b1;
        isReady   = 1'b0;
      end else if (pending && cyc == readyAt) begin
        expNext = 3'(pendPiece);
        pending = 1'b0;
        isReady = 1'b1;
      end else if (isReady && fr && Game_State == 3'd1 && En_New_Static) begin
        expActive[expNext] = 1'b1;
        bagUsed[expNext]   = 1'b1;
        isReady = 1'b0;
        full = 1'b1;
        for (int k = 0; k < NP; k++) if (!bagUsed[k]) full = 1'b0;
        if (full) for (int k = 0; k < NP; k++) bagUsed[k] = 1'b0;
      end
      prevFrame = frame_clk;
      prevGame  = Game_State;
    end
  end

  // Compare process: every cycle, just after the clock edge.
  always @(posedge Clk) begin
    #1;
    checkOutput("key_press", 32'(key_press), 32'(expPress));
    checkOutput("key_held", 32'(key_held), 32'(expHeld));
    checkOutput("Active", 32'(Active), 32'(expActive));
    checkOutput("next_piece", 32'(next_piece), 32'(expNext));
  end

  // Activity monitor used by the directed literal checks.
  int            pressCount[NK];
  logic [NP-1:0] activeLog[$];

  initial for (int i = 0; i < NK; i++) pressCount[i] = 0;

  always @(posedge Clk) begin
    #1;
    for (int i = 0; i < NK; i++) if (key_press[i] === 1'b1) pressCount[i]++;
    if (Active !== '0) activeLog.push_back(Active);
  end

  // Hold a keycode for exactly n rising clock edges.
  task automatic applyStimulus(input logic [7:0] kc, input int n);
    @(negedge Clk);
    keycode = kc;
    repeat (n - 1) @(negedge Clk);
  endtask

  task automatic frameHalf(input bit lvl);
    @(negedge Clk);
    frame_clk = lvl;
    repeat (H) @(negedge Clk);
  endtask

  task automatic frames(input int n);
    repeat (n) begin
      frameHalf(1'b1);
      frameHalf(1'b0);
    end
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

  int base0, base1, base2, base4;
  int expSeq[11] = '{3, 4, 5, 6, 0, 1, 2, 3, 3, 4, 0};
  logic [NP-1:0] unionBits;

  initial begin
    Reset         = 1'b1;
    keycode       = 8'd80;
    frame_clk     = 1'b0;
    randnum       = 3'd0;
    Game_State    = 3'd0;
    En_New_Static = 1'b0;

    // Reset with LEFT already down, then release.
    repeat (2) @(negedge Clk);
    base0 = pressCount[K_LEFT];
    Reset = 1'b0;
    @(posedge Clk);
    #1;
    checkOutput("t1_press_left", 32'(key_press[K_LEFT]), 32'd1);
    checkOutput("t1_held_left", 32'(key_held[K_LEFT]), 32'd1);
    repeat (3) @(negedge Clk);
    checkOutput("t1_single_pulse", 32'(pressCount[K_LEFT] - base0), 32'd1);

    // LEFT held: repeats on rise 10, then every 2 rises.
    frames(9);
    checkOutput("t2_before_das", 32'(pressCount[K_LEFT] - base0), 32'd1);
    frames(1);
    checkOutput("t2_das", 32'(pressCount[K_LEFT] - base0), 32'd2);
    frames(5);
    checkOutput("t2_arr", 32'(pressCount[K_LEFT] - base0), 32'd4);
    applyStimulus(8'd0, 1);
    frames(3);
    checkOutput("t2_release", 32'(pressCount[K_LEFT] - base0), 32'd4);

    // UP has no repeat; SPACE is a level.
    base2 = pressCount[K_UP];
    applyStimulus(8'd82, 1);
    frames(20);
    checkOutput("t3_up_once", 32'(pressCount[K_UP] - base2), 32'd1);
    base4 = pressCount[K_SPACE];
    applyStimulus(8'd44, 30);
    applyStimulus(8'd0, 3);
    checkOutput("t3_space_level", 32'(pressCount[K_SPACE] - base4), 32'd30);

    // LEFT -> RIGHT directly, then back to LEFT: full DAS needed again.
    applyStimulus(8'd80, 1);
    frames(5);
    base0 = pressCount[K_LEFT];
    base1 = pressCount[K_RIGHT];
    applyStimulus(8'd79, 3);
    checkOutput("t4_right_press", 32'(pressCount[K_RIGHT] - base1), 32'd1);
    checkOutput("t4_left_quiet", 32'(pressCount[K_LEFT] - base0), 32'd0);
    applyStimulus(8'd80, 1);
    frames(9);
    checkOutput("t4_left_restart", 32'(pressCount[K_LEFT] - base0), 32'd1);
    frames(1);
    checkOutput("t4_left_das", 32'(pressCount[K_LEFT] - base0), 32'd2);
    applyStimulus(8'd0, 2);

    // Bag draws: prime with randnum=3, then play eight frames.
    randnum = 3'd3;
    frames(1);
    @(negedge Clk);
    Game_State    = 3'd1;
    En_New_Static = 1'b1;
    frames(8);
    checkOutput("t5_count", 32'(activeLog.size()), 32'd8);
    unionBits = '0;
    for (int k = 0; k < 7; k++) if (k < activeLog.size()) unionBits |= activeLog[k];
    checkOutput("t5_full_bag", 32'(unionBits), 32'h7f);

    // No spawn without En_New_Static; re-entering play clears the bag.
    En_New_Static = 1'b0;
    frameHalf(1'b1);
    checkOutput("t6_no_spawn", 32'(activeLog.size()), 32'd8);
    Game_State = 3'd0;
    repeat (3) @(negedge Clk);
    Game_State = 3'd1;
    En_New_Static = 1'b1;
    repeat (2) @(negedge Clk);
    frameHalf(1'b0);
    frames(1);
    frameHalf(1'b1);
    randnum = 3'd7;
    frameHalf(1'b0);
    frames(1);

    for (int k = 0; k < 11; k++) begin
      logic [NP-1:0] got;
      logic [NP-1:0] want;
      got  = (k < activeLog.size()) ? activeLog[k] : '0;
      want = '0;
      want[expSeq[k]] = 1'b1;
      checkOutput($sformatf("spawn_%0d", k), 32'(got), 32'(want));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
